// File: rtl/cpu_clk_ctrl_if.sv
// cpu_clk_ctrl_if: board-side and CPU-side signals of the clock controller.
// master drives the switches/button/halt, slave is the controller.
interface cpu_clk_ctrl_if;
  logic        frq_switch;
  logic        run_sw;
  logic        step_btn;
  logic        halt_req;
  logic        cpu_ce;
  logic        cpu_clk;
  logic        halted;
  logic [1:0]  mode;
  logic [31:0] ce_count;

  modport master (
    output frq_switch, run_sw, step_btn, halt_req,
    input  cpu_ce, cpu_clk, halted, mode, ce_count
  );

  modport slave (
    input  frq_switch, run_sw, step_btn, halt_req,
    output cpu_ce, cpu_clk, halted, mode, ce_count
  );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: run/step/halt controller producing the CPU clock enable.
// Free-run at two speeds, debounced single step, halt on CPU request.
module cpu_clk_ctrl #(
  parameter int unsigned FAST_DIV   = 31,
  parameter int unsigned SLOW_DIV   = 2500001,
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input logic           clk_in,
  input logic           rst,
  cpu_clk_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    STEP = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [31:0] FAST_LAST = 32'(FAST_DIV - 1);
  localparam logic [31:0] SLOW_LAST = 32'(SLOW_DIV - 1);
  localparam logic [31:0] DEB_LAST  = 32'(DEB_CYCLES - 1);

  state_t      state;
  logic [1:0]  frq_q;
  logic [1:0]  run_q;
  logic [1:0]  btn_q;
  logic        frq_s;
  logic        run_s;
  logic        btn_s;
  logic        stable;
  logic        step_evt;
  logic [31:0] deb_cnt;
  logic [31:0] cnt;
  logic [31:0] div_last;
  logic        div_sel;
  logic        wrap;
  logic        fire;
  logic        ce;
  logic        clk_q;
  logic        halted_q;
  logic [31:0] ce_cnt;

  assign frq_s    = frq_q[1];
  assign run_s    = run_q[1];
  assign btn_s    = btn_q[1];
  assign div_last = div_sel ? FAST_LAST : SLOW_LAST;
  assign wrap     = (cnt == div_last);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      frq_q <= '0;
      run_q <= '0;
      btn_q <= '0;
    end else begin
      frq_q <= {frq_q[0], bus.frq_switch};
      run_q <= {run_q[0], bus.run_sw};
      btn_q <= {btn_q[0], bus.step_btn};
    end
  end

  // Accept a new button level only after it has held for DEB_CYCLES.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      stable   <= 1'b0;
      deb_cnt  <= '0;
      step_evt <= 1'b0;
    end else begin
      step_evt <= 1'b0;
      if (btn_s == stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        stable   <= btn_s;
        deb_cnt  <= '0;
        step_evt <= btn_s;
      end else begin
        deb_cnt <= deb_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    fire = 1'b0;
    unique case (state)
      STEP:    fire = step_evt && !ce;
      RUN:     fire = wrap && !bus.halt_req;
      default: fire = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state    <= STEP;
      cnt      <= '0;
      div_sel  <= 1'b1;
      ce       <= 1'b0;
      clk_q    <= 1'b0;
      halted_q <= 1'b0;
      ce_cnt   <= '0;
    end else begin
      ce <= fire;
      if (fire) begin
        clk_q  <= ~clk_q;
        ce_cnt <= ce_cnt + 32'd1;
      end
      // Speed changes only land on a period boundary.
      if (state != RUN || wrap)
        div_sel <= frq_s;
      unique case (state)
        STEP: begin
          cnt <= '0;
          if (run_s)
            state <= RUN;
        end
        RUN: begin
          if (bus.halt_req) begin
            state    <= HALT;
            halted_q <= 1'b1;
            cnt      <= '0;
          end else if (wrap) begin
            cnt <= '0;
            if (!run_s)
              state <= STEP;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        HALT: begin
          cnt <= '0;
          if (step_evt && !bus.halt_req) begin
            state    <= run_s ? RUN : STEP;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state <= STEP;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.cpu_ce   = ce;
  assign bus.cpu_clk  = clk_q;
  assign bus.halted   = halted_q;
  assign bus.mode     = state;
  assign bus.ce_count = ce_cnt;
endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb_cpu_clk_ctrl: directed checks of run, speed change, step, halt
// and reset behaviour with FAST_DIV=4, SLOW_DIV=10, DEB_CYCLES=3.
module tb_cpu_clk_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc;
  int   errs;
  int   c0;
  int   e0;
  int   np;
  int unsigned pq[$];

  cpu_clk_ctrl_if bus();

  cpu_clk_ctrl #(
    .FAST_DIV  (4),
    .SLOW_DIV  (10),
    .DEB_CYCLES(3)
  ) dut (
    .clk_in(clk),
    .rst   (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc_step();
    @(negedge clk);
    cyc++;
    if (bus.cpu_ce === 1'b1)
      pq.push_back(cyc);
  endtask

  function automatic int unsigned pat(input int i);
    return (i < pq.size()) ? pq[i] : 0;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    errs     = 0;
    rst            = 1'b1;
    bus.run_sw     = 1'b1;
    bus.frq_switch = 1'b1;
    bus.step_btn   = 1'b0;
    bus.halt_req   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ce", bus.cpu_ce, 0);
    chk("rst_clk", bus.cpu_clk, 0);
    chk("rst_mode", bus.mode, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_count", bus.ce_count, 0);
    rst = 1'b0;

    // Fast free-run: pulses at 7, 11, ..., 51
    for (int k = 1; k <= 52; k++) begin
      cyc_step();
      if (bus.cpu_ce !== ((cyc >= 7 && (cyc - 7) % 4 == 0) ? 1'b1 : 1'b0))
        errs++;
      if (k == 2) chk("mode_pre_run", bus.mode, 0);
      if (k == 3) chk("mode_run", bus.mode, 1);
      if (k == 6) chk("no_early_ce", bus.cpu_ce, 0);
      if (k == 7) chk("first_ce", bus.cpu_ce, 1);
      if (k == 7) chk("clk_hi", bus.cpu_clk, 1);
      if (k == 11) chk("clk_lo", bus.cpu_clk, 0);
    end
    chk("run_pattern_errs", errs, 0);
    chk("count_fast", bus.ce_count, 12);
    pq.delete();

    // Speed flip at cnt=1, then leave run mode
    bus.frq_switch = 1'b0;
    while (cyc < 75) cyc_step();
    bus.run_sw = 1'b0;
    while (cyc < 90) cyc_step();
    chk("slow_npulse", pq.size(), 4);
    chk("slow_p0", pat(0), 55);
    chk("slow_p1", pat(1), 65);
    chk("slow_p2", pat(2), 75);
    chk("stop_pulse", pat(3), 85);
    chk("mode_step", bus.mode, 0);
    chk("count_slow", bus.ce_count, 16);

    // Bouncy step press and release
    pq.delete();
    bus.step_btn = 1'b1;
    cyc_step();
    bus.step_btn = 1'b0;
    cyc_step();
    bus.step_btn = 1'b1;
    repeat (10) cyc_step();
    chk("step_press", pq.size(), 1);
    chk("count_step", bus.ce_count, 17);
    bus.step_btn = 1'b0;
    repeat (10) cyc_step();
    chk("step_release", pq.size(), 1);
    chk("mode_after_step", bus.mode, 0);

    // Halt just before a due pulse
    pq.delete();
    c0 = cyc;
    bus.run_sw     = 1'b1;
    bus.frq_switch = 1'b1;
    repeat (10) cyc_step();
    bus.halt_req = 1'b1;
    cyc_step();
    chk("reentry_npulse", pq.size(), 1);
    chk("reentry_delay", pat(0) - c0, 7);
    chk("halt_no_ce", bus.cpu_ce, 0);
    chk("halt_flag", bus.halted, 1);
    chk("halt_mode", bus.mode, 2);
    chk("count_halt", bus.ce_count, 18);

    bus.step_btn = 1'b1;
    repeat (8) cyc_step();
    bus.step_btn = 1'b0;
    repeat (8) cyc_step();
    chk("halt_ignores_step", bus.mode, 2);
    chk("halt_npulse", pq.size(), 1);

    bus.halt_req = 1'b0;
    bus.step_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc_step();
      if (bus.mode == 2'd1) break;
    end
    chk("halt_exit_mode", bus.mode, 1);
    chk("halt_exit_flag", bus.halted, 0);
    bus.step_btn = 1'b0;
    np = pq.size();
    e0 = cyc;
    repeat (4) cyc_step();
    chk("exit_npulse", pq.size() - np, 1);
    chk("exit_delay", pat(np) - e0, 4);
    chk("count_exit", bus.ce_count, 19);

    // Reset mid-run at cnt=2 with cpu_clk high
    repeat (2) cyc_step();
    chk("clk_before_rst", bus.cpu_clk, 1);
    rst = 1'b1;
    cyc_step();
    chk("midrst_ce", bus.cpu_ce, 0);
    chk("midrst_clk", bus.cpu_clk, 0);
    chk("midrst_count", bus.ce_count, 0);
    chk("midrst_mode", bus.mode, 0);

    // Idle step mode
    pq.delete();
    bus.run_sw = 1'b0;
    rst = 1'b0;
    repeat (100) cyc_step();
    chk("idle_npulse", pq.size(), 0);
    chk("idle_mode", bus.mode, 0);
    chk("idle_count", bus.ce_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
